// File: rtl/weights_chainer_cfg.sv
// weights_chainer_cfg: packs a stream of DATA_WID-bit words into groups of
// up to MAX_CHAIN words and emits each group as one wide word.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   en_input                 global input enable (output side always drains)
//   cfg_len, cfg_msb_first   group length / slot order, sampled on first word
//   flush                    emit the current partial group
//   in_dat/in_vld/in_rdy     input word handshake
//   out_dat/out_cnt          packed group and its word count
//   out_vld/out_rdy          output handshake (one holding slot)
//   busy                     partial group present in the accumulator
module weights_chainer_cfg #(
    parameter int DATA_WID  = 16,
    parameter int MAX_CHAIN = 4,
    parameter int CNT_WID   = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_input,
    input  logic [CNT_WID-1:0]            cfg_len,
    input  logic                          cfg_msb_first,
    input  logic                          flush,
    input  logic [DATA_WID-1:0]           in_dat,
    input  logic                          in_vld,
    output logic                          in_rdy,
    output logic [DATA_WID*MAX_CHAIN-1:0] out_dat,
    output logic [CNT_WID-1:0]            out_cnt,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic                          busy
);

    localparam int                 OUT_WID = DATA_WID * MAX_CHAIN;
    localparam logic [CNT_WID-1:0] LEN_MAX = CNT_WID'(MAX_CHAIN);
    localparam logic [CNT_WID-1:0] ONE     = CNT_WID'(1);

    logic [OUT_WID-1:0] r_acc;
    logic [CNT_WID-1:0] r_count;
    logic [CNT_WID-1:0] r_len_q;
    logic               r_order_q;
    logic [OUT_WID-1:0] r_out_dat;
    logic [CNT_WID-1:0] r_out_cnt;
    logic               r_out_vld;
    logic               r_flush_pend;

    logic [CNT_WID-1:0] w_len_cfg;
    logic               w_first;
    logic [CNT_WID-1:0] w_len;
    logic               w_order;
    logic               w_last;
    logic               w_slot_free;
    logic               w_accept;
    logic [CNT_WID-1:0] w_slot;
    logic [OUT_WID-1:0] w_acc_n;
    logic [CNT_WID-1:0] w_cnt_n;
    logic               w_emit_full;
    logic               w_flush_req;
    logic               w_flush_go;
    logic               w_load;

    always_comb begin
        w_len_cfg   = cfg_len;
        if (cfg_len == '0 || cfg_len > LEN_MAX) begin
            w_len_cfg = LEN_MAX;
        end

        // Length/order come from the config ports only for the first word
        // of a group; afterwards the latched copies rule.
        w_first     = (r_count == '0);
        w_len       = w_first ? w_len_cfg : r_len_q;
        w_order     = w_first ? cfg_msb_first : r_order_q;
        w_last      = (r_count == w_len - ONE);
        w_slot_free = !r_out_vld || out_rdy;

        // Non-last words may keep filling while the holding slot is busy;
        // a pending flush freezes the accumulator until it can move out.
        in_rdy      = !rst && en_input && !r_flush_pend &&
                      (!w_last || w_slot_free);
        w_accept    = in_vld && in_rdy;

        w_slot      = w_order ? (w_len - ONE - r_count) : r_count;
        w_acc_n     = r_acc;
        for (int s = 0; s < MAX_CHAIN; s++) begin
            if (w_accept && w_slot == CNT_WID'(s)) begin
                w_acc_n[s*DATA_WID +: DATA_WID] = in_dat;
            end
        end
        w_cnt_n     = r_count + {{(CNT_WID-1){1'b0}}, w_accept};

        // A flush that coincides with a last-word accept is absorbed by
        // the full-group emission.
        w_emit_full = w_accept && w_last;
        w_flush_req = (flush && (w_cnt_n != '0) && !w_emit_full) ||
                      r_flush_pend;
        w_flush_go  = w_flush_req && w_slot_free;
        w_load      = w_emit_full || w_flush_go;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc        <= '0;
            r_count      <= '0;
            r_len_q      <= '0;
            r_order_q    <= 1'b0;
            r_out_dat    <= '0;
            r_out_cnt    <= '0;
            r_out_vld    <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_accept && w_first) begin
                r_len_q   <= w_len_cfg;
                r_order_q <= cfg_msb_first;
            end

            if (w_load) begin
                r_acc   <= '0;
                r_count <= '0;
            end else begin
                r_acc   <= w_acc_n;
                r_count <= w_cnt_n;
            end

            // Loading a new group on the transfer edge keeps out_vld high.
            if (w_load) begin
                r_out_dat <= w_acc_n;
                r_out_cnt <= w_cnt_n;
                r_out_vld <= 1'b1;
            end else if (out_rdy) begin
                r_out_vld <= 1'b0;
            end

            r_flush_pend <= w_flush_req && !w_flush_go;
        end
    end

    assign out_dat = r_out_dat;
    assign out_cnt = r_out_cnt;
    assign out_vld = r_out_vld;
    assign busy    = !rst && (r_count != '0);

endmodule

// File: tb/tb_weights_chainer_cfg.sv
module tb_weights_chainer_cfg;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_input;
    logic [2:0]  cfg_len;
    logic        cfg_msb_first;
    logic        flush;
    logic [15:0] in_dat;
    logic        in_vld;
    logic        in_rdy;
    logic [63:0] out_dat;
    logic [2:0]  out_cnt;
    logic        out_vld;
    logic        out_rdy;
    logic        busy;

    int checks = 0;
    int errors = 0;

    weights_chainer_cfg #(
        .DATA_WID  (16),
        .MAX_CHAIN (4),
        .CNT_WID   (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en_input      (en_input),
        .cfg_len       (cfg_len),
        .cfg_msb_first (cfg_msb_first),
        .flush         (flush),
        .in_dat        (in_dat),
        .in_vld        (in_vld),
        .in_rdy        (in_rdy),
        .out_dat       (out_dat),
        .out_cnt       (out_cnt),
        .out_vld       (out_vld),
        .out_rdy       (out_rdy),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Reference model: current group as a word list, plus the output slot.
    logic [15:0] m_words[$];
    int          m_len;
    bit          m_ord;
    bit          m_hv;
    logic [63:0] m_hd;
    int          m_hc;
    bit          m_pend;
    bit          m_ok;
    bit          e_rdy;
    bit          e_free;
    bit          e_acc;
    int          n_acc;
    int          last_cyc;
    logic [63:0] xfer_q[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int l);
        return (l == 0 || l > 4) ? 4 : l;
    endfunction

    task automatic predict();
        int le;
        bit last;
        le     = (m_words.size() == 0) ? sat(int'(cfg_len)) : m_len;
        last   = (m_words.size() == le - 1);
        e_free = !m_hv || out_rdy;
        e_rdy  = !rst && en_input && !m_pend && (!last || e_free);
        e_acc  = in_vld && e_rdy;
        if (m_ok) begin
            chk("in_rdy", 64'(in_rdy), 64'(e_rdy));
            chk("out_vld", 64'(out_vld), 64'(m_hv));
            chk("out_dat", out_dat, m_hd);
            chk("out_cnt", 64'(out_cnt), 64'(m_hc));
            chk("busy", 64'(busy),
                64'(!rst && m_words.size() != 0));
        end
        if (out_vld && out_rdy) xfer_q.push_back(out_dat);
    endtask

    task automatic model_edge();
        bit full;
        bit freq;
        bit go;
        int slot;
        if (rst) begin
            m_words.delete();
            m_hv   = 0;
            m_hd   = '0;
            m_hc   = 0;
            m_pend = 0;
            m_ok   = 1;
            return;
        end
        if (e_acc) begin
            if (m_words.size() == 0) begin
                m_len = sat(int'(cfg_len));
                m_ord = cfg_msb_first;
            end
            m_words.push_back(in_dat);
            n_acc++;
        end
        full = e_acc && (m_words.size() == m_len);
        freq = (flush && m_words.size() > 0 && !full) || m_pend;
        go   = freq && e_free;
        if (full || go) begin
            m_hd = '0;
            foreach (m_words[k]) begin
                slot = m_ord ? (m_len - 1 - k) : k;
                m_hd[slot*16 +: 16] = m_words[k];
            end
            m_hc = m_words.size();
            m_hv = 1;
            m_words.delete();
        end else if (out_rdy) begin
            m_hv = 0;
        end
        m_pend = freq && !go;
    endtask

    task automatic cyc();
        @(negedge clk);
        predict();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        int n0;
        n0       = n_acc;
        in_dat   = w;
        in_vld   = 1'b1;
        last_cyc = 0;
        for (int i = 0; i < 40 && n_acc == n0; i++) begin
            cyc();
            last_cyc++;
        end
        chk("push_accept", 64'(n_acc), 64'(n0 + 1));
        in_vld = 1'b0;
    endtask

    initial begin
        int w;
        int n0;
        rst           = 1'b1;
        en_input      = 1'b1;
        cfg_len       = 3'd4;
        cfg_msb_first = 1'b0;
        flush         = 1'b0;
        in_dat        = '0;
        in_vld        = 1'b0;
        out_rdy       = 1'b1;
        m_ok          = 0;
        n_acc         = 0;
        m_hv          = 0;
        m_hd          = '0;
        m_hc          = 0;
        m_pend        = 0;

        cyc();
        cyc();
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_out_dat", out_dat, 64'd0);
        chk("rst_out_cnt", 64'(out_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd0);
        rst = 1'b0;
        cyc();

        push(16'h0001);
        chk("fill_busy", 64'(busy), 64'd1);
        push(16'h0002);
        push(16'h0003);
        push(16'h0004);
        chk("g_lsb_vld", 64'(out_vld), 64'd1);
        chk("g_lsb_dat", out_dat, 64'h0004_0003_0002_0001);
        chk("g_lsb_cnt", 64'(out_cnt), 64'd4);
        chk("g_lsb_busy", 64'(busy), 64'd0);
        cyc();
        chk("g_lsb_drop", 64'(out_vld), 64'd0);

        cfg_msb_first = 1'b1;
        for (int i = 1; i <= 4; i++) push(16'(i));
        chk("g_msb_dat", out_dat, 64'h0001_0002_0003_0004);
        cyc();
        cfg_len       = 3'd2;
        cfg_msb_first = 1'b0;
        push(16'h000A);
        cfg_len       = 3'd4;
        cfg_msb_first = 1'b1;
        push(16'h000B);
        chk("g_len2_vld", 64'(out_vld), 64'd1);
        chk("g_len2_dat", out_dat, 64'h0000_0000_000B_000A);
        chk("g_len2_cnt", 64'(out_cnt), 64'd2);
        cfg_msb_first = 1'b0;
        cyc();

        out_rdy = 1'b0;
        xfer_q.delete();
        w = 1;
        for (int i = 0; i < 20; i++) begin
            in_dat = 16'(w);
            in_vld = 1'b1;
            n0     = n_acc;
            cyc();
            if (n_acc != n0) w++;
        end
        chk("bp_accepted", 64'(w - 1), 64'd7);
        chk("bp_in_rdy", 64'(in_rdy), 64'd0);
        chk("bp_hold_dat", out_dat, 64'h0004_0003_0002_0001);
        out_rdy = 1'b1;
        for (int i = 0; i < 40 && w <= 12; i++) begin
            in_dat = 16'(w);
            in_vld = 1'b1;
            n0     = n_acc;
            cyc();
            if (n_acc != n0) w++;
        end
        in_vld = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("bp_xfers", 64'(xfer_q.size()), 64'd3);
        if (xfer_q.size() == 3) begin
            chk("bp_x0", xfer_q[0], 64'h0004_0003_0002_0001);
            chk("bp_x1", xfer_q[1], 64'h0008_0007_0006_0005);
            chk("bp_x2", xfer_q[2], 64'h000C_000B_000A_0009);
        end

        cfg_len = 3'd3;
        for (int i = 1; i <= 5; i++) push(16'(i));
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("fl_vld", 64'(out_vld), 64'd1);
        chk("fl_cnt", 64'(out_cnt), 64'd2);
        chk("fl_dat", out_dat, 64'h0000_0000_0005_0004);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("fl_empty", 64'(out_vld), 64'd0);
        cyc();
        chk("fl_empty2", 64'(out_vld), 64'd0);

        cfg_len = 3'd4;
        push(16'h0001);
        push(16'h0002);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_vld", 64'(out_vld), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        for (int i = 5; i <= 8; i++) push(16'(i));
        chk("mid_rst_dat", out_dat, 64'h0008_0007_0006_0005);
        chk("mid_rst_cnt", 64'(out_cnt), 64'd4);
        cyc();

        cfg_len = 3'd1;
        for (int i = 0; i < 8; i++) begin
            push(16'(16'h0100 + i));
            chk("len1_cyc", 64'(last_cyc), 64'd1);
            chk("len1_dat", out_dat, 64'(16'h0100 + i));
            chk("len1_cnt", 64'(out_cnt), 64'd1);
        end
        cyc();

        for (int i = 0; i < 1500; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            en_input      = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) begin
                cfg_len       = 3'($urandom_range(0, 7));
                cfg_msb_first = 1'($urandom_range(0, 1));
            end
            flush         = ($urandom_range(0, 9) == 0);
            in_vld        = ($urandom_range(0, 3) != 0);
            in_dat        = 16'($urandom);
            out_rdy       = ($urandom_range(0, 2) != 0);
            cyc();
        end
        rst      = 1'b0;
        en_input = 1'b1;
        flush    = 1'b0;
        in_vld   = 1'b0;
        out_rdy  = 1'b1;
        for (int i = 0; i < 4; i++) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
